mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single DPI-backed physical memory port between the instruction fetch unit (IFU) and the load/store unit (LSU) of the NPC core.
- Accepts one request at a time from either requester and arbitrates round-robin when both request together.
- Drives the downstream memory handshake and routes the response back to the owner.
- A response watchdog returns an error response if memory never answers.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; the write mask is DATA_W/8 bits.
- TIMEOUT, 255, number of cycles waited in RESP before the watchdog fires; minimum 1.
- ERR_DATA, 32'hFFFF_FFFF, rdata returned on a watchdog timeout.

Ports:
- clock in 1: single clock, all state on the rising edge.
- reset in 1: synchronous, active-high.
- ifu_req_valid in 1: IFU request present.
- ifu_req_ready out 1: IFU request accepted this cycle.
- ifu_addr in ADDR_W: fetch address.
- ifu_resp_valid out 1: IFU response pulse.
- ifu_rdata out DATA_W: fetched instruction.
- lsu_req_valid in 1: LSU request present.
- lsu_req_ready out 1: LSU request accepted this cycle.
- lsu_addr in ADDR_W: load/store address.
- lsu_wen in 1: 1 = store, 0 = load.
- lsu_wdata in DATA_W: store data.
- lsu_wmask in DATA_W/8: byte enables for a store.
- lsu_resp_valid out 1: LSU response pulse.
- lsu_rdata out DATA_W: load data.
- mem_req_valid out 1: downstream request.
- mem_req_ready in 1: downstream accepts the request.
- mem_addr out ADDR_W: downstream address.
- mem_wen out 1: downstream write enable.
- mem_wdata out DATA_W: downstream write data.
- mem_wmask out DATA_W/8: downstream byte enables.
- mem_resp_valid in 1: downstream response.
- mem_rdata in DATA_W: downstream read data.
- timeout_err out 1: one-cycle pulse when the watchdog fires.

Behaviour:
- States are IDLE, REQ and RESP. Registers: owner (IFU/LSU), last_grant, latched addr/wen/wdata/wmask, wdog counter.
- Reset values:
  - state = IDLE, last_grant = LSU (so IFU wins the first contention), wdog = 0.
  - All outputs are 0, and all mem_* payload outputs are 0.
- IDLE:
  - Exactly one requester valid: grant it. Both valid: grant the one that is not last_grant.
  - The granted requester's req_ready = 1 combinationally in the same cycle; the other ready = 0. With no valid request, both ready = 0.
  - On grant: latch the payload. IFU grants force wen = 0 and wmask = 0.
  - On grant: set owner and last_grant, then go to REQ.
- REQ:
  - mem_req_valid = 1 with the latched payload. The payload is held stable until mem_req_ready.
  - On mem_req_valid & mem_req_ready: go to RESP and clear wdog.
  - Earliest mem_req_valid is 1 cycle after acceptance.
- RESP:
  - mem_req_valid = 0.
  - When mem_resp_valid = 1: assert <owner>_resp_valid combinationally in the same cycle. <owner>_rdata = mem_rdata for loads/fetches, 0 for stores. Go to IDLE.
  - Otherwise wdog increments. When wdog == TIMEOUT-1 and there is no response: owner resp_valid = 1, rdata = ERR_DATA, timeout_err = 1, go to IDLE.
- Response outputs:
  - Non-owner resp_valid is always 0.
  - Every resp_valid is a single-cycle pulse.
  - rdata is 0 whenever its resp_valid is 0.
- mem_resp_valid is ignored in IDLE and REQ, so a late response after a timeout is dropped.
- Exactly one transaction is outstanding at a time; both req_ready are 0 outside IDLE.
- Minimum transaction turnaround is 3 cycles: accept → REQ → RESP with immediate ready and response. The next request can be accepted in the cycle after the response.
- Reset asserted in any state returns to IDLE on the next edge with the reset values above. An in-flight transaction is abandoned and no response pulse is generated.
- An upstream valid dropped before ready is legal and leaves no state change.

Test Plan:
- Single IFU fetch:
  - Stimulus: ifu_addr = 0x80000000, mem_req_ready = 1, mem_resp_valid 2 cycles after issue with mem_rdata = 0x00000413.
  - Required: ifu_req_ready in cycle 0, mem_req_valid in cycle 1, ifu_resp_valid with rdata 0x00000413 in cycle 3, lsu_resp_valid stays 0.
- Contention:
  - Stimulus: both request every cycle after reset.
  - Required: grant order IFU, LSU, IFU, LSU. LSU store payload 0x80001000/0xDEADBEEF/mask 0xF appears on mem_*. lsu_rdata = 0 on the store response.
- Backpressure:
  - Stimulus: mem_req_ready held 0 for 5 cycles.
  - Required: mem_req_valid and payload stable for 5 cycles, both upstream ready = 0, transaction completes normally afterwards.
- Timeout:
  - Stimulus: TIMEOUT = 4, no mem_resp_valid.
  - Required: 4 cycles after the mem handshake, owner resp_valid with rdata 0xFFFFFFFF and timeout_err pulse. A mem_resp_valid arriving later produces no upstream response.
- Reset mid-operation:
  - Stimulus: assert reset while in RESP.
  - Required: no resp_valid, next cycle IDLE with all outputs 0, and the next contention grants IFU.
- Idle/withdraw:
  - Stimulus: lsu_req_valid pulsed for 1 cycle while in REQ for an IFU fetch.
  - Required: no LSU acceptance; arbiter returns to IDLE after the IFU response and issues nothing further.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin IFU/LSU arbiter for the shared memory port
module mem_port_arbiter #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hFFFF_FFFF)
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                ifu_req_valid_i,
  output logic                ifu_req_ready_o,
  input  logic [ADDR_W-1:0]   ifu_addr_i,
  output logic                ifu_resp_valid_o,
  output logic [DATA_W-1:0]   ifu_rdata_o,
  input  logic                lsu_req_valid_i,
  output logic                lsu_req_ready_o,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic                lsu_wen_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_wmask_i,
  output logic                lsu_resp_valid_o,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_wen_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic                mem_resp_valid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                timeout_err_o
);

  localparam int unsigned      MASK_W    = DATA_W / 8;
  localparam int unsigned      WDOG_W    = $clog2(TIMEOUT + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;

  logic                grant_ifu;
  logic                grant_lsu;
  logic                resp_hit;
  logic                wdog_fire;
  logic                resp_fire;
  logic [DATA_W-1:0]   resp_data;
  logic                in_req;

  // Contention goes to whichever side did not win last; reset biases toward IFU.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state_q == ST_IDLE && !reset_i) begin
      if (ifu_req_valid_i && lsu_req_valid_i) begin
        grant_ifu = (last_grant_q == OWN_LSU);
        grant_lsu = (last_grant_q == OWN_IFU);
      end else begin
        grant_ifu = ifu_req_valid_i;
        grant_lsu = lsu_req_valid_i;
      end
    end
  end

  always_comb begin
    resp_hit  = (state_q == ST_RESP) && mem_resp_valid_i && !reset_i;
    wdog_fire = (state_q == ST_RESP) && !mem_resp_valid_i &&
                (wdog_q == WDOG_LAST) && !reset_i;
    resp_fire = resp_hit || wdog_fire;
    if (wdog_fire) begin
      resp_data = ERR_DATA;
    end else if (wen_q) begin
      resp_data = '0;
    end else begin
      resp_data = mem_rdata_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    wdog_d       = wdog_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_ifu) begin
          addr_d       = ifu_addr_i;
          wen_d        = 1'b0;
          wdata_d      = '0;
          wmask_d      = '0;
          owner_d      = OWN_IFU;
          last_grant_d = OWN_IFU;
          state_d      = ST_REQ;
        end else if (grant_lsu) begin
          addr_d       = lsu_addr_i;
          wen_d        = lsu_wen_i;
          wdata_d      = lsu_wdata_i;
          wmask_d      = lsu_wmask_i;
          owner_d      = OWN_LSU;
          last_grant_d = OWN_LSU;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_req_ready_i) begin
          state_d = ST_RESP;
          wdog_d  = '0;
        end
      end
      ST_RESP: begin
        if (resp_fire) begin
          state_d = ST_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IFU;
      last_grant_q <= OWN_LSU;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      wdog_q       <= wdog_d;
    end
  end

  // Payload is visible only while a request is presented downstream.
  assign in_req          = (state_q == ST_REQ);
  assign mem_req_valid_o = in_req;
  assign mem_addr_o      = in_req ? addr_q  : '0;
  assign mem_wen_o       = in_req ? wen_q   : 1'b0;
  assign mem_wdata_o     = in_req ? wdata_q : '0;
  assign mem_wmask_o     = in_req ? wmask_q : '0;

  assign ifu_req_ready_o  = grant_ifu;
  assign lsu_req_ready_o  = grant_lsu;
  assign ifu_resp_valid_o = resp_fire && (owner_q == OWN_IFU);
  assign lsu_resp_valid_o = resp_fire && (owner_q == OWN_LSU);
  assign ifu_rdata_o      = ifu_resp_valid_o ? resp_data : '0;
  assign lsu_rdata_o      = lsu_resp_valid_o ? resp_data : '0;
  assign timeout_err_o    = wdog_fire;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int unsigned TO      = 4;
  localparam logic [31:0] ERR_VAL = 32'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_last;

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .ERR_DATA(ERR_VAL)
  ) dut (
    .clock_i(clock), .reset_i(reset),
    .ifu_req_valid_i(ifu_req_valid), .ifu_req_ready_o(ifu_req_ready),
    .ifu_addr_i(ifu_addr), .ifu_resp_valid_o(ifu_resp_valid), .ifu_rdata_o(ifu_rdata),
    .lsu_req_valid_i(lsu_req_valid), .lsu_req_ready_o(lsu_req_ready),
    .lsu_addr_i(lsu_addr), .lsu_wen_i(lsu_wen), .lsu_wdata_i(lsu_wdata),
    .lsu_wmask_i(lsu_wmask), .lsu_resp_valid_o(lsu_resp_valid), .lsu_rdata_o(lsu_rdata),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_addr_o(mem_addr), .mem_wen_o(mem_wen), .mem_wdata_o(mem_wdata),
    .mem_wmask_o(mem_wmask), .mem_resp_valid_i(mem_resp_valid),
    .mem_rdata_i(mem_rdata), .timeout_err_o(timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 64'(|{ifu_req_ready, lsu_req_ready, ifu_resp_valid, ifu_rdata,
                   lsu_resp_valid, lsu_rdata, mem_req_valid, mem_addr, mem_wen,
                   mem_wdata, mem_wmask, timeout_err}), 64'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    tick();
    reset = 1'b0;
    exp_last = 1'b1;
    settle();
    chk_all_zero("reset_outputs");
  endtask

  task automatic idle(input int n, input bit late_resp);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      mem_resp_valid = late_resp && (k == 0);
      mem_rdata = $urandom;
      settle();
      chk("idle_mem_valid", 64'(mem_req_valid), 64'(0));
      chk("idle_resp", 64'({ifu_resp_valid, lsu_resp_valid, timeout_err}), 64'(0));
      chk("idle_ready", 64'({ifu_req_ready, lsu_req_ready}), 64'(0));
      tick();
    end
    mem_resp_valid = 1'b0;
    mem_req_ready = 1'b0;
  endtask

  // Transaction-level reference: round-robin winner, latched payload, response rule.
  task automatic txn(input bit iv, input bit lv, input logic [31:0] ia, input logic [31:0] la,
                     input bit lw, input logic [31:0] lwd, input logic [3:0] lm,
                     input int stall, input int rdly, input logic [31:0] rd,
                     input bit hold, input bit poke, output bit won);
    bit          win, is_resp, is_to;
    logic [31:0] e_addr, e_data;
    bit          e_wen;
    logic [3:0]  e_mask;
    ifu_req_valid = iv; ifu_addr = ia;
    lsu_req_valid = lv; lsu_addr = la; lsu_wen = lw; lsu_wdata = lwd; lsu_wmask = lm;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    win = (iv && lv) ? !exp_last : lv;
    exp_last = win;
    e_addr = win ? la : ia;
    e_wen  = win ? lw : 1'b0;
    e_mask = win ? lm : 4'h0;
    settle();
    chk("grant_ifu", 64'(ifu_req_ready), 64'(!win));
    chk("grant_lsu", 64'(lsu_req_ready), 64'(win));
    chk("accept_no_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'(0));
    won = lsu_req_ready;
    tick();
    if (!hold) begin
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    end
    for (int s = 0; s <= stall; s++) begin
      mem_req_ready = (s == stall);
      if (poke && s == 0) lsu_req_valid = 1'b1;
      settle();
      chk("req_valid", 64'(mem_req_valid), 64'(1));
      chk("req_addr", 64'(mem_addr), 64'(e_addr));
      chk("req_wen_mask", 64'({mem_wen, mem_wmask}), 64'({e_wen, e_mask}));
      if (win) chk("req_wdata", 64'(mem_wdata), 64'(lwd));
      chk("req_ready_busy", 64'({ifu_req_ready, lsu_req_ready}), 64'(0));
      tick();
      if (poke && !hold) lsu_req_valid = 1'b0;
    end
    mem_req_ready = 1'b0;
    for (int c = 0; c < int'(TO); c++) begin
      is_resp = (c == rdly) && (rdly < int'(TO));
      is_to   = !is_resp && (c == int'(TO) - 1);
      mem_resp_valid = is_resp;
      mem_rdata = is_resp ? rd : $urandom;
      settle();
      chk("resp_mem_valid", 64'(mem_req_valid), 64'(0));
      chk("resp_ready_busy", 64'({ifu_req_ready, lsu_req_ready}), 64'(0));
      e_data = is_to ? ERR_VAL : (e_wen ? 32'h0 : rd);
      if (is_resp || is_to) begin
        chk("resp_ifu_valid", 64'(ifu_resp_valid), 64'(!win));
        chk("resp_lsu_valid", 64'(lsu_resp_valid), 64'(win));
        chk("resp_ifu_rdata", 64'(ifu_rdata), win ? 64'(0) : 64'(e_data));
        chk("resp_lsu_rdata", 64'(lsu_rdata), win ? 64'(e_data) : 64'(0));
        chk("resp_timeout", 64'(timeout_err), 64'(is_to));
      end else begin
        chk("wait_no_resp", 64'({ifu_resp_valid, lsu_resp_valid, timeout_err}), 64'(0));
        chk("wait_rdata_zero", 64'({ifu_rdata, lsu_rdata}), 64'(0));
      end
      tick();
      mem_resp_valid = 1'b0;
      if (is_resp || is_to) break;
    end
  endtask

  initial begin
    bit w;
    ifu_addr = '0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    mem_rdata = '0;
    do_reset();

    // Single IFU fetch: accept cycle 0, issue cycle 1, response cycle 3.
    txn(1, 0, 32'h8000_0000, 32'h0, 0, 32'h0, 4'h0, 0, 1, 32'h0000_0413, 0, 0, w);
    idle(1, 0);

    // Contention from reset: IFU, LSU, IFU, LSU with an LSU store.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      txn(1, 1, 32'h8000_0100, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF, 0, 0, $urandom, 1, 0, w);
      chk("contention_order", 64'(w), 64'(i % 2));
    end
    idle(1, 0);

    // Backpressure: 5 stalled cycles then completion.
    txn(0, 1, 32'h0, 32'h8000_2004, 0, 32'h1234_5678, 4'h3, 5, 0, 32'hCAFE_F00D, 1, 0, w);
    idle(1, 0);

    // Watchdog expiry, then a late response that must be dropped.
    txn(0, 1, 32'h0, 32'h8000_3000, 0, 32'h0, 4'h0, 1, 99, 32'h0, 0, 0, w);
    idle(3, 1);

    // Reset while waiting in RESP.
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_4000; lsu_req_valid = 1'b0;
    tick();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h5555_AAAA; reset = 1'b1;
    settle();
    chk("reset_mid_no_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'(0));
    tick();
    reset = 1'b0; mem_resp_valid = 1'b0;
    exp_last = 1'b1;
    settle();
    chk_all_zero("reset_mid_outputs");
    txn(1, 1, 32'h8000_5000, 32'h8000_6000, 0, 32'h0, 4'h0, 0, 0, 32'h0BAD_F00D, 0, 0, w);
    chk("reset_mid_ifu_first", 64'(w), 64'(0));

    // LSU pulses during an IFU request phase and is never accepted.
    txn(1, 0, 32'h8000_7000, 32'h0, 0, 32'h0, 4'h0, 0, 1, 32'h1357_9BDF, 0, 1, w);
    idle(4, 0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      bit iv, lv;
      iv = 1'($urandom_range(1, 0));
      lv = 1'($urandom_range(1, 0));
      if (!iv && !lv) begin
        idle(int'($urandom_range(2, 1)), 1'($urandom_range(1, 0)));
      end else begin
        txn(iv, lv, $urandom, $urandom, 1'($urandom_range(1, 0)), $urandom,
            4'($urandom), int'($urandom_range(3, 0)), int'($urandom_range(5, 0)),
            $urandom, 1'($urandom_range(1, 0)), 1'b0, w);
      end
    end
    idle(1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
